// File: rtl/debounce_multi.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : debounce_multi
// Purpose  : Multi-channel push-button / switch debouncer. Each channel is
//            synchronised, sampled on a shared prescaled tick and accepted
//            after STABLE_SAMPLES consecutive samples that differ from the
//            current clean level. Provides a held level, an edge pulse per
//            channel and a combined pulse flag.
// Revision : 1.0 - initial release
// ============================================================================
module debounce_multi #(
    parameter int CHANNELS       = 4,
    parameter int DIVISOR        = 25000000,
    parameter int STABLE_SAMPLES = 3,
    parameter int EDGE_MODE      = 0
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [CHANNELS-1:0] i_signal,
    output logic [CHANNELS-1:0] o_level,
    output logic [CHANNELS-1:0] o_pulse,
    output logic                o_any,
    output logic                o_tick
);

    // Prescaler counter needs at least one bit even when DIVISOR is 1.
    localparam int c_DIV_W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam int c_CNT_W = $clog2(STABLE_SAMPLES + 1);

    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(DIVISOR - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(STABLE_SAMPLES - 1);

    // Edge selection: unknown modes fall back to rising-edge pulses.
    localparam bit c_RISE_EN = (EDGE_MODE != 1);
    localparam bit c_FALL_EN = (EDGE_MODE == 1) || (EDGE_MODE == 2);

    logic [CHANNELS-1:0] r_sync1;
    logic [CHANNELS-1:0] r_sync2;
    logic [c_DIV_W-1:0]  r_div_cnt;
    logic                r_tick;
    logic [CHANNELS-1:0] w_level;
    logic [CHANNELS-1:0] w_pulse;

    // Two-flop synchroniser bringing the raw inputs into the clock domain.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= i_signal;
            r_sync2 <= r_sync1;
        end
    end

    // Shared free-running prescaler; the tick is registered so it is high
    // in the cycle after the counter reaches its last value.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_div_cnt <= '0;
            r_tick    <= 1'b0;
        end else if (r_div_cnt == c_DIV_LAST) begin
            r_div_cnt <= '0;
            r_tick    <= 1'b1;
        end else begin
            r_div_cnt <= r_div_cnt + c_DIV_W'(1);
            r_tick    <= 1'b0;
        end
    end

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            logic [c_CNT_W-1:0] r_count;
            logic               r_level;
            logic               r_pulse;

            // Qualify a level change over consecutive differing tick samples;
            // any sample matching the current level restarts the count.
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    r_count <= '0;
                    r_level <= 1'b0;
                    r_pulse <= 1'b0;
                end else begin
                    r_pulse <= 1'b0;
                    if (r_tick) begin
                        if (r_sync2[gi] == r_level) begin
                            r_count <= '0;
                        end else if (r_count != c_CNT_LAST) begin
                            r_count <= r_count + c_CNT_W'(1);
                        end else begin
                            r_level <= r_sync2[gi];
                            r_count <= '0;
                            r_pulse <= r_sync2[gi] ? c_RISE_EN : c_FALL_EN;
                        end
                    end
                end
            end

            assign w_level[gi] = r_level;
            assign w_pulse[gi] = r_pulse;
        end
    endgenerate

    assign o_level = w_level;
    assign o_pulse = w_pulse;
    assign o_any   = |w_pulse;
    assign o_tick  = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_debounce_multi.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_debounce_multi
// Purpose  : Self-checking bench for debounce_multi. Four instances share one
//            stimulus: (DIV=4, both edges), (DIV=4, rising), (DIV=4, falling)
//            and (DIV=1, both edges). A sample-history reference model
//            predicts every output on every clock.
// Revision : 1.0 - initial release
// ============================================================================
module tb_debounce_multi;

    localparam int NCFG = 4;
    localparam int SS   = 3;
    localparam int DIVS [NCFG] = '{4, 4, 4, 1};
    localparam int EMS  [NCFG] = '{2, 0, 1, 2};

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] sig;
    logic [7:0] lvl_all;
    logic [7:0] pul_all;
    logic [3:0] any_all;
    logic [3:0] tick_all;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    int         ek;
    logic [1:0] h1, h2;
    logic [1:0] m_lvl  [NCFG];
    logic [1:0] m_pul  [NCFG];
    logic       m_tick [NCFG];
    int         m_run  [NCFG][2];

    always #5 clk = ~clk;

    debounce_multi #(.CHANNELS(2), .DIVISOR(4), .STABLE_SAMPLES(SS), .EDGE_MODE(2)) u_both (
        .i_clk(clk), .i_rst(rst), .i_signal(sig),
        .o_level(lvl_all[1:0]), .o_pulse(pul_all[1:0]), .o_any(any_all[0]), .o_tick(tick_all[0]));
    debounce_multi #(.CHANNELS(2), .DIVISOR(4), .STABLE_SAMPLES(SS), .EDGE_MODE(0)) u_rise (
        .i_clk(clk), .i_rst(rst), .i_signal(sig),
        .o_level(lvl_all[3:2]), .o_pulse(pul_all[3:2]), .o_any(any_all[1]), .o_tick(tick_all[1]));
    debounce_multi #(.CHANNELS(2), .DIVISOR(4), .STABLE_SAMPLES(SS), .EDGE_MODE(1)) u_fall (
        .i_clk(clk), .i_rst(rst), .i_signal(sig),
        .o_level(lvl_all[5:4]), .o_pulse(pul_all[5:4]), .o_any(any_all[2]), .o_tick(tick_all[2]));
    debounce_multi #(.CHANNELS(2), .DIVISOR(1), .STABLE_SAMPLES(SS), .EDGE_MODE(2)) u_fast (
        .i_clk(clk), .i_rst(rst), .i_signal(sig),
        .o_level(lvl_all[7:6]), .o_pulse(pul_all[7:6]), .o_any(any_all[3]), .o_tick(tick_all[3]));

    function automatic logic [23:0] obs();
        logic [23:0] v;
        for (int d = 0; d < NCFG; d++)
            v[6*d +: 6] = {lvl_all[2*d +: 2], pul_all[2*d +: 2], any_all[d], tick_all[d]};
        return v;
    endfunction

    function automatic logic [23:0] exp_vec();
        logic [23:0] v;
        for (int d = 0; d < NCFG; d++)
            v[6*d +: 6] = {m_lvl[d], m_pul[d], |m_pul[d], m_tick[d]};
        return v;
    endfunction

    task automatic model_reset();
        ek = 0;
        h1 = '0;
        h2 = '0;
        for (int d = 0; d < NCFG; d++) begin
            m_lvl[d]  = '0;
            m_pul[d]  = '0;
            m_tick[d] = 1'b0;
            m_run[d][0] = 0;
            m_run[d][1] = 0;
        end
    endtask

    // One clock edge: ek counts edges since reset release; the value the
    // debouncer samples at edge ek is the input seen two edges earlier (h2).
    // Samples are taken at edges ek = 1 + k*DIV (k >= 1); a level is adopted
    // after SS consecutive samples that differ from it.
    task automatic model_edge();
        ek++;
        for (int d = 0; d < NCFG; d++) begin
            m_pul[d] = '0;
            if (ek >= DIVS[d] + 1 && (ek - 1) % DIVS[d] == 0) begin
                for (int c = 0; c < 2; c++) begin
                    if (h2[c] == m_lvl[d][c]) begin
                        m_run[d][c] = 0;
                    end else begin
                        m_run[d][c] = m_run[d][c] + 1;
                        if (m_run[d][c] == SS) begin
                            m_lvl[d][c] = h2[c];
                            m_run[d][c] = 0;
                            m_pul[d][c] = h2[c] ? (EMS[d] != 1) : (EMS[d] == 1 || EMS[d] == 2);
                        end
                    end
                end
            end
            m_tick[d] = (ek >= DIVS[d]) && (ek % DIVS[d] == 0);
        end
        h2 = h1;
        h1 = sig;
    endtask

    task automatic cyc();
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sig = 2'b00;
        model_reset();
        #2;
        vectors++;
        if (obs() !== 24'h0) begin
            miscompares++;
            $display("FAIL reset_initial got=%h want=%h", obs(), 24'h0);
        end
        repeat (3) begin
            cyc();
            vectors++;
            if (obs() !== exp_vec()) begin
                miscompares++;
                $display("FAIL reset_hold got=%h want=%h", obs(), exp_vec());
            end
        end
        #2 rst = 1'b0;
    endtask

    task automatic test_clean_step();
        int lat = 0, pulses = 0, anys = 0;
        bit ch1_bad = 1'b0;
        sig = 2'b00;
        repeat (24) begin
            cyc();
            vectors++;
            if (obs() !== exp_vec()) begin
                miscompares++;
                $display("FAIL step_idle got=%h want=%h", obs(), exp_vec());
            end
        end
        sig[0] = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            cyc();
            vectors++;
            if (obs() !== exp_vec()) begin
                miscompares++;
                $display("FAIL step_track cyc=%0d got=%h want=%h", i, obs(), exp_vec());
            end
            if (pul_all[0]) pulses++;
            if (any_all[0]) anys++;
            if (lvl_all[1] || pul_all[1]) ch1_bad = 1'b1;
            if (lat == 0 && lvl_all[0]) lat = i;
        end
        vectors++;
        if (lat < 11 || lat > 14) begin
            miscompares++;
            $display("FAIL step_latency got=%0d want=11..14", lat);
        end
        vectors++;
        if (pulses != 1 || anys != 1) begin
            miscompares++;
            $display("FAIL step_pulse got pulses=%0d any=%0d want 1/1", pulses, anys);
        end
        vectors++;
        if (ch1_bad) begin
            miscompares++;
            $display("FAIL step_ch1_quiet got=1 want=0");
        end
    endtask

    task automatic test_short_glitch();
        int pulses = 0, anys = 0;
        bit rose = 1'b0;
        sig = 2'b00;
        repeat (24) begin
            cyc();
            vectors++;
            if (obs() !== exp_vec()) begin
                miscompares++;
                $display("FAIL glitch_settle got=%h want=%h", obs(), exp_vec());
            end
        end
        for (int i = 0; i < 28; i++) begin
            sig[0] = (i < 8);
            cyc();
            vectors++;
            if (obs() !== exp_vec()) begin
                miscompares++;
                $display("FAIL glitch_track cyc=%0d got=%h want=%h", i, obs(), exp_vec());
            end
            if (lvl_all[0]) rose = 1'b1;
            if (pul_all[0]) pulses++;
            if (any_all[0]) anys++;
        end
        vectors++;
        if (rose || pulses != 0 || anys != 0) begin
            miscompares++;
            $display("FAIL glitch_reject got rose=%0d pulses=%0d any=%0d want 0/0/0", rose, pulses, anys);
        end
    endtask

    task automatic test_bounce();
        int pulses = 0, late_changes = 0;
        logic prev;
        sig = 2'b00;
        for (int i = 0; i < 70; i++) begin
            sig[0] = (i < 30) ? ~sig[0] : 1'b1;
            prev = lvl_all[0];
            cyc();
            vectors++;
            if (obs() !== exp_vec()) begin
                miscompares++;
                $display("FAIL bounce_track cyc=%0d got=%h want=%h", i, obs(), exp_vec());
            end
            if (pul_all[0]) pulses++;
            if (i >= 46 && lvl_all[0] != prev) late_changes++;
        end
        vectors++;
        if (pulses != 1 || lvl_all[0] !== 1'b1 || late_changes != 0) begin
            miscompares++;
            $display("FAIL bounce_result got pulses=%0d level=%b late=%0d want 1/1/0",
                     pulses, lvl_all[0], late_changes);
        end
    endtask

    task automatic test_edge_modes();
        int rise_p = 0, rise_f = 0, fall_p = 0, fall_f = 0;
        logic lr_hi, lf_hi;
        sig = 2'b00;
        for (int i = 0; i < 75; i++) begin
            sig[0] = (i >= 25 && i < 50);
            cyc();
            vectors++;
            if (obs() !== exp_vec()) begin
                miscompares++;
                $display("FAIL edge_track cyc=%0d got=%h want=%h", i, obs(), exp_vec());
            end
            if (i >= 25 && i < 50) begin
                if (pul_all[2]) rise_p++;
                if (pul_all[4]) rise_f++;
            end else if (i >= 50) begin
                if (pul_all[2]) fall_p++;
                if (pul_all[4]) fall_f++;
            end
            if (i == 49) begin
                lr_hi = lvl_all[2];
                lf_hi = lvl_all[4];
            end
        end
        vectors++;
        if (rise_p != 1 || fall_p != 0 || lr_hi !== 1'b1 || lvl_all[2] !== 1'b0) begin
            miscompares++;
            $display("FAIL edge_rising_mode got rise=%0d fall=%0d hi=%b end=%b want 1/0/1/0",
                     rise_p, fall_p, lr_hi, lvl_all[2]);
        end
        vectors++;
        if (rise_f != 0 || fall_f != 1 || lf_hi !== 1'b1 || lvl_all[4] !== 1'b0) begin
            miscompares++;
            $display("FAIL edge_falling_mode got rise=%0d fall=%0d hi=%b end=%b want 0/1/1/0",
                     rise_f, fall_f, lf_hi, lvl_all[4]);
        end
    endtask

    task automatic test_simultaneous();
        bit seen = 1'b0;
        sig = 2'b00;
        repeat (25) cyc();
        sig = 2'b11;
        for (int i = 0; i < 30 && !seen; i++) begin
            cyc();
            vectors++;
            if (obs() !== exp_vec()) begin
                miscompares++;
                $display("FAIL simul_track got=%h want=%h", obs(), exp_vec());
            end
            if (lvl_all[1:0] != 2'b00) seen = 1'b1;
        end
        vectors++;
        if (!seen || lvl_all[1:0] !== 2'b11 || pul_all[1:0] !== 2'b11 || any_all[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL simul_edge got lvl=%b pul=%b any=%b want 11/11/1",
                     lvl_all[1:0], pul_all[1:0], any_all[0]);
        end
        cyc();
        vectors++;
        if (pul_all[1:0] !== 2'b00 || any_all[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL simul_after got pul=%b any=%b want 00/0", pul_all[1:0], any_all[0]);
        end
    endtask

    task automatic test_async_reset();
        int lat0 = 0, lat3 = 0, pulses0 = 0;
        bit tick_drop = 1'b0;
        sig = 2'b01;
        repeat (25) cyc();
        sig[0] = 1'b0;
        repeat (5) cyc();
        vectors++;
        if (lvl_all[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL arst_pre_level got=%b want=1", lvl_all[0]);
        end
        #2;
        rst    = 1'b1;
        sig[0] = 1'b1;
        #1;
        model_reset();
        vectors++;
        if (obs() !== 24'h0) begin
            miscompares++;
            $display("FAIL arst_immediate got=%h want=%h", obs(), 24'h0);
        end
        repeat (2) cyc();
        #2 rst = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            cyc();
            vectors++;
            if (obs() !== exp_vec()) begin
                miscompares++;
                $display("FAIL arst_track cyc=%0d got=%h want=%h", i, obs(), exp_vec());
            end
            if (lat0 == 0 && lvl_all[0]) lat0 = i;
            if (lat3 == 0 && lvl_all[6]) lat3 = i;
            if (pul_all[0]) pulses0++;
            if (!tick_all[3]) tick_drop = 1'b1;
        end
        vectors++;
        if (lat0 < 11 || pulses0 != 1) begin
            miscompares++;
            $display("FAIL arst_reaccept got lat=%0d pulses=%0d want >=11/1", lat0, pulses0);
        end
        vectors++;
        if (lat3 != 5 || tick_drop) begin
            miscompares++;
            $display("FAIL arst_div1 got lat=%0d tick_drop=%0d want 5/0", lat3, tick_drop);
        end
    endtask

    task automatic test_random();
        for (int s = 0; s < 30; s++) begin
            sig = 2'($urandom_range(0, 3));
            repeat ($urandom_range(1, 16)) begin
                cyc();
                vectors++;
                if (obs() !== exp_vec()) begin
                    miscompares++;
                    $display("FAIL random_track seg=%0d got=%h want=%h", s, obs(), exp_vec());
                end
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_clean_step();
        test_short_glitch();
        test_bounce();
        test_edge_modes();
        test_simultaneous();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/debounce_multi.md
Name: debounce_multi

Overview:
Parametrised multi-channel debouncer for push-buttons and switches feeding the 8051 SoC peripherals. Each channel is synchronised, sampled on a shared prescaled tick, and qualified over a programmable number of consecutive stable samples. Each channel provides a held clean level and a one-clock pulse for the selected edge(s). A combined pulse flag is provided for interrupt generation.

Parameters:
CHANNELS, 4, number of independent input channels (>=1)
DIVISOR, 25000000, sample tick period in i_clk cycles (>=1; 1 = tick every cycle)
STABLE_SAMPLES, 3, consecutive differing samples required to accept a new level (>=1)
EDGE_MODE, 0, pulse edge select: 0 = rising, 1 = falling, 2 = both; any other value behaves as 0

Ports:
i_clk  input  1  system clock; all state updates on rising edge
i_rst  input  1  asynchronous, active-high reset
i_signal  input  CHANNELS  raw bouncing inputs, asynchronous to i_clk
o_level  output  CHANNELS  debounced held level per channel
o_pulse  output  CHANNELS  one-cycle strobe per channel on the qualifying edge of o_level
o_any  output  1  OR-reduction of o_pulse (combinational from registered o_pulse)
o_tick  output  1  registered sample tick; high one cycle every DIVISOR cycles

Behaviour:
- Reset (async, i_rst=1): prescaler counter=0, o_tick=0, sync flops=0, per-channel stable counters=0, o_level=0, o_pulse=0, o_any=0. All outputs clear immediately, without waiting for a clock edge.
- Synchroniser: two-flop synchroniser per channel. sync_q = i_signal delayed 2 cycles.
- Prescaler:
  - Counter width $clog2(DIVISOR), minimum 1 bit.
  - Increments every cycle. At DIVISOR-1, wraps to 0 and asserts o_tick for that one following cycle.
  - DIVISOR=1: o_tick held high continuously after the first clock following reset.
  - Counter is shared by all channels; no per-channel phase.
- Per-channel qualification, evaluated only in cycles where o_tick=1:
  - sync_q == o_level: count <= 0.
  - sync_q != o_level and count < STABLE_SAMPLES-1: count <= count+1.
  - sync_q != o_level and count == STABLE_SAMPLES-1: o_level <= sync_q and count <= 0.
  - Count width is $clog2(STABLE_SAMPLES+1). The count saturates and never wraps.
  - In cycles with o_tick=0, count and o_level hold.
- Pulse:
  - o_pulse[i] is registered and asserts on the same clock edge that o_level[i] changes, when the edge matches EDGE_MODE.
  - It deasserts on the next edge. It is never wider than one cycle and never asserts without a level change.
- Latency:
  - A clean step is accepted on the STABLE_SAMPLES-th tick whose sample sees the new value.
  - Worst case from input change to o_level change: 2 + STABLE_SAMPLES*DIVISOR cycles.
  - Best case: 2 + (STABLE_SAMPLES-1)*DIVISOR + 1 cycles.
- Glitch rejection: any tick sample equal to the current o_level restarts qualification from 0.
- Simultaneous events: channels are fully independent. Several channels may update and pulse in the same cycle, and o_any is high for that one cycle.
- Reset mid-operation: partial counts are discarded. After release, an input already held high needs the full 2 + STABLE_SAMPLES ticks to be accepted, and it produces a rising pulse.
- Width rule: all internal widths are derived from parameters. No truncation warnings are permitted at defaults.

Test Plan:
Unless noted, CHANNELS=2, DIVISOR=4, STABLE_SAMPLES=3, EDGE_MODE=2.
1. ch0 clean step 0->1, held -> o_level[0] rises between 11 and 14 cycles after the step; o_pulse[0] and o_any high exactly 1 cycle on that edge; ch1 outputs stay 0.
2. ch0 high for exactly 2 tick samples, then low -> o_level[0] stays 0; no o_pulse, o_any stays 0 throughout.
3. ch0 toggles every cycle for 30 cycles, then settles high -> exactly one o_pulse[0]; final o_level[0]=1; no intermediate level changes after settling.
4. EDGE_MODE=0: ch0 rises then falls, each held >= 20 cycles -> one pulse on the rise; o_level returns to 0 on the fall with no pulse. Repeat with EDGE_MODE=1 -> pulse only on the fall.
5. ch0 and ch1 step high in the same cycle -> both o_level bits rise in the same cycle; o_pulse=2'b11 for 1 cycle; o_any high 1 cycle.
6. Assert i_rst asynchronously (between clock edges) with o_level[0]=1 and a count in progress -> o_level, o_pulse, o_tick and o_any read 0 before the next clock edge. After release with ch0 still high -> o_level[0] re-rises after >= 11 cycles with one pulse. DIVISOR=1 variant -> o_tick constantly 1, acceptance in 2+3 cycles.
